// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencer: FSM state encoding,
// command codes and default widths.
package counter_ctrl_pkg;

   localparam int W_DEF       = 8;
   localparam int PRESC_W_DEF = 4;

   localparam logic [1:0] CMD_LOAD   = 2'b00;
   localparam logic [1:0] CMD_RUN_N  = 2'b01;
   localparam logic [1:0] CMD_RUN_TO = 2'b10;
   localparam logic [1:0] CMD_FREE   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command handshake and counter-pin bundle between the ui_in decode, the
// sequencer and counter_8bit.
interface counter_seq_ctrl_if #(
   parameter int W       = 8,
   parameter int PRESC_W = 4
);
   logic               start;
   logic [1:0]         cmd;
   logic [W-1:0]       operand;
   logic [PRESC_W-1:0] presc;
   logic               abort;
   logic [W-1:0]       cnt_q;
   logic               cnt_load;
   logic [W-1:0]       cnt_data;
   logic               cnt_en;
   logic               busy;
   logic               done;
   logic               err;
   logic               aborted;

   modport master (
      output start, cmd, operand, presc, abort, cnt_q,
      input  cnt_load, cnt_data, cnt_en, busy, done, err, aborted
   );

   modport slave (
      input  start, cmd, operand, presc, abort, cnt_q,
      output cnt_load, cnt_data, cnt_en, busy, done, err, aborted
   );
endinterface

// File: rtl/counter_seq_ctrl_tick_prescaler.sv
// Programmable tick generator: one tick every (presc+1) cycles, held at
// zero while clr is asserted so the first active cycle starts a fresh period.
module tick_prescaler
   import counter_ctrl_pkg::*;
#(
   parameter int PRESC_W = PRESC_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] pcnt_q;
   logic [PRESC_W-1:0] pcnt_d;

   always_comb begin
      tick   = (pcnt_q == presc);
      pcnt_d = pcnt_q + 1'b1;
      if (clr || tick) begin
         pcnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for counter_8bit: accepts LOAD / RUN_N / RUN_TO / FREE
// commands over a start/busy/done handshake and drives load/data/enable pins.
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int PRESC_W = PRESC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   counter_seq_ctrl_if.slave    bus
);

   state_e             state_q,   state_d;
   logic [1:0]         cmd_q,     cmd_d;
   logic [W-1:0]       op_q,      op_d;
   logic [W-1:0]       rem_q,     rem_d;
   logic [PRESC_W-1:0] presc_q,   presc_d;
   logic [W:0]         tcnt_q,    tcnt_d;
   logic               err_q,     err_d;
   logic               aborted_q, aborted_d;

   logic tick;
   logic pre_clr;
   logic stop;
   logic en;

   tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pre_clr),
      .presc (presc_q),
      .tick  (tick)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      op_d      = op_q;
      rem_d     = rem_q;
      presc_d   = presc_q;
      tcnt_d    = tcnt_q;
      err_d     = err_q;
      aborted_d = aborted_q;
      pre_clr   = (state_q != RUN);

      // End condition is evaluated every RUN cycle, not only on ticks,
      // so completion never waits for a further prescaler period.
      unique case (cmd_q)
         CMD_RUN_N:  stop = (rem_q == '0);
         CMD_RUN_TO: stop = (bus.cnt_q == op_q) || tcnt_q[W];
         CMD_FREE:   stop = 1'b0;
         default:    stop = 1'b1;
      endcase

      en = (state_q == RUN) && tick && !stop && !bus.abort;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               cmd_d     = bus.cmd;
               op_d      = bus.operand;
               presc_d   = bus.presc;
               rem_d     = bus.operand;
               tcnt_d    = '0;
               err_d     = 1'b0;
               aborted_d = 1'b0;
               state_d   = (bus.cmd == CMD_LOAD) ? LOAD : RUN;
            end
         end
         LOAD: state_d = DONE;
         RUN: begin
            if (bus.abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (stop) begin
               err_d   = (cmd_q == CMD_RUN_TO) && tcnt_q[W] && (bus.cnt_q != op_q);
               state_d = DONE;
            end else if (en) begin
               if (cmd_q == CMD_RUN_N) begin
                  rem_d = rem_q - 1'b1;
               end
               if (cmd_q == CMD_RUN_TO) begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cmd_q     <= CMD_LOAD;
         op_q      <= '0;
         rem_q     <= '0;
         presc_q   <= '0;
         tcnt_q    <= '0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         presc_q   <= presc_d;
         tcnt_q    <= tcnt_d;
         err_q     <= err_d;
         aborted_q <= aborted_d;
      end
   end

   assign bus.cnt_load = (state_q == LOAD);
   assign bus.cnt_data = op_q;
   assign bus.cnt_en   = en;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
   assign bus.err      = err_q;
   assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Randomised and directed bench for counter_seq_ctrl with a behavioural
// 8-bit counter as the plant and a per-command schedule model.
module tb_counter_seq_ctrl;
   import counter_ctrl_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   counter_seq_ctrl_if #(.W(8), .PRESC_W(4)) bus_if ();

   counter_seq_ctrl #(.W(8), .PRESC_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Plant: counter_8bit stand-in; tie forces cnt_q to zero for the timeout case.
   logic [7:0] q = 8'h00;
   bit         tie = 1'b0;
   always @(posedge clk) begin
      if (bus_if.cnt_load)    q <= bus_if.cnt_data;
      else if (bus_if.cnt_en) q <= q + 8'd1;
   end
   assign bus_if.cnt_q = tie ? 8'h00 : q;

   // Model: phase 0 idle, 1 load, 2 run, 3 done. A run issues m_n enables,
   // one at the end of each (m_p+1)-cycle period, then stops the next cycle.
   int         m_phase = 0;
   int         m_c = 0;
   int         m_n = 0;
   int         m_p = 0;
   logic [7:0] m_op = 8'h00;
   bit         m_err = 0;
   bit         m_abt = 0;
   bit         m_to_err = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0; m_c <= 0; m_n <= 0; m_p <= 0;
         m_op <= 8'h00; m_err <= 0; m_abt <= 0; m_to_err <= 0;
      end else begin
         case (m_phase)
            0: if (bus_if.start) begin
               m_op     <= bus_if.operand;
               m_p      <= int'(bus_if.presc);
               m_err    <= 0;
               m_abt    <= 0;
               m_c      <= 0;
               m_to_err <= 0;
               m_phase  <= (bus_if.cmd == CMD_LOAD) ? 1 : 2;
               case (bus_if.cmd)
                  CMD_RUN_N: m_n <= int'(bus_if.operand);
                  CMD_RUN_TO: begin
                     if (bus_if.cnt_q == bus_if.operand) m_n <= 0;
                     else if (tie) begin m_n <= 256; m_to_err <= 1; end
                     else m_n <= (int'(bus_if.operand) - int'(bus_if.cnt_q) + 256) % 256;
                  end
                  CMD_FREE: m_n <= -1;
                  default:  m_n <= 0;
               endcase
            end
            1: m_phase <= 3;
            2: begin
               if (bus_if.abort) begin
                  m_abt <= 1; m_phase <= 3;
               end else if (m_n >= 0 && m_c == m_n * (m_p + 1)) begin
                  m_err <= m_to_err; m_phase <= 3;
               end else begin
                  m_c <= m_c + 1;
               end
            end
            default: m_phase <= 0;
         endcase
      end
   end

   int en_total   = 0;
   int done_total = 0;

   always @(negedge clk) begin
      bit exp_en;
      exp_en = (m_phase == 2) && !bus_if.abort && (m_c % (m_p + 1) == m_p)
               && (m_n < 0 || m_c < m_n * (m_p + 1));
      chk("cnt_load", int'(bus_if.cnt_load), int'(m_phase == 1));
      chk("cnt_data", int'(bus_if.cnt_data), int'(m_op));
      chk("cnt_en",   int'(bus_if.cnt_en),   int'(exp_en));
      chk("busy",     int'(bus_if.busy),     int'(m_phase != 0));
      chk("done",     int'(bus_if.done),     int'(m_phase == 3));
      chk("err",      int'(bus_if.err),      int'(m_err));
      chk("aborted",  int'(bus_if.aborted),  int'(m_abt));
      if (bus_if.cnt_en) en_total++;
      if (bus_if.done)   done_total++;
   end

   task automatic issue(input logic [1:0] c, input logic [7:0] o, input logic [3:0] p);
      chk("idle_before_start", int'(bus_if.busy), 0);
      bus_if.start   = 1'b1;
      bus_if.cmd     = c;
      bus_if.operand = o;
      bus_if.presc   = p;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
   endtask

   task automatic run_cmd(input logic [1:0] c, input logic [7:0] o, input logic [3:0] p,
                          input int abort_at, input int busy_start_at, input int limit,
                          output int ens, output int dones);
      int  e0;
      int  d0;
      bit  seen;
      e0   = en_total;
      d0   = done_total;
      seen = 0;
      issue(c, o, p);
      for (int k = 0; k < limit; k++) begin
         if (k == abort_at) bus_if.abort = 1'b1;
         if (k == busy_start_at) begin
            bus_if.start   = 1'b1;
            bus_if.cmd     = CMD_LOAD;
            bus_if.operand = 8'hEE;
         end
         @(negedge clk);
         if (bus_if.done) seen = 1;
         @(posedge clk); #1;
         bus_if.abort = 1'b0;
         bus_if.start = 1'b0;
         if (seen) break;
      end
      if (!seen) chk("done_timeout", 0, 1);
      ens   = en_total - e0;
      dones = done_total - d0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, d;
      bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.cmd = CMD_LOAD;
      bus_if.operand = 8'h00; bus_if.presc = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(bus_if.busy), 0);
      chk("reset_data", int'(bus_if.cnt_data), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run_cmd(CMD_LOAD, 8'h5A, 4'd0, -1, -1, 20, e, d);
      $display("LOAD 0x5A: en=%0d done=%0d q=%h", e, d, q);
      chk("t1_q", int'(q), 8'h5A); chk("t1_en", e, 0); chk("t1_done", d, 1);

      run_cmd(CMD_RUN_N, 8'd3, 4'd0, -1, -1, 20, e, d);
      $display("RUN_N 3: en=%0d done=%0d q=%h", e, d, q);
      chk("t2_q", int'(q), 8'h5D); chk("t2_en", e, 3); chk("t2_done", d, 1);
      run_cmd(CMD_RUN_N, 8'd0, 4'd0, -1, -1, 20, e, d);
      $display("RUN_N 0: en=%0d done=%0d q=%h", e, d, q);
      chk("t2b_en", e, 0); chk("t2b_done", d, 1);

      run_cmd(CMD_LOAD, 8'h0C, 4'd0, -1, -1, 20, e, d);
      run_cmd(CMD_RUN_TO, 8'h10, 4'd2, -1, -1, 100, e, d);
      $display("RUN_TO 0x10 p2: en=%0d done=%0d q=%h err=%0d", e, d, q, bus_if.err);
      chk("t3_q", int'(q), 8'h10); chk("t3_en", e, 4); chk("t3_err", int'(bus_if.err), 0);
      run_cmd(CMD_RUN_TO, 8'h10, 4'd2, -1, -1, 100, e, d);
      $display("RUN_TO at target: en=%0d done=%0d", e, d);
      chk("t3b_en", e, 0); chk("t3b_done", d, 1);

      run_cmd(CMD_LOAD, 8'hFE, 4'd0, -1, -1, 20, e, d);
      run_cmd(CMD_RUN_TO, 8'h01, 4'd0, -1, -1, 100, e, d);
      $display("RUN_TO wrap: en=%0d done=%0d q=%h", e, d, q);
      chk("t4_q", int'(q), 8'h01); chk("t4_en", e, 3);
      tie = 1'b1;
      run_cmd(CMD_RUN_TO, 8'h01, 4'd0, -1, -1, 400, e, d);
      $display("RUN_TO timeout: en=%0d done=%0d err=%0d", e, d, bus_if.err);
      chk("t4b_err", int'(bus_if.err), 1); chk("t4b_en", e, 256); chk("t4b_done", d, 1);
      tie = 1'b0;

      run_cmd(CMD_FREE, 8'h00, 4'd0, 10, 4, 50, e, d);
      $display("FREE abort@10: en=%0d done=%0d aborted=%0d q=%h", e, d, bus_if.aborted, q);
      chk("t5_en", e, 10); chk("t5_done", d, 1);
      chk("t5_aborted", int'(bus_if.aborted), 1); chk("t5_q", int'(q), 8'h0B);

      issue(CMD_RUN_N, 8'd50, 4'd0);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      $display("reset mid RUN_N: busy=%0d en=%0d done=%0d", bus_if.busy, bus_if.cnt_en, bus_if.done);
      chk("t6_busy", int'(bus_if.busy), 0); chk("t6_en", int'(bus_if.cnt_en), 0);
      chk("t6_load", int'(bus_if.cnt_load), 0); chk("t6_done", int'(bus_if.done), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_busy_after", int'(bus_if.busy), 0);
      run_cmd(CMD_LOAD, 8'h33, 4'd0, -1, -1, 20, e, d);
      $display("LOAD after reset: done=%0d q=%h", d, q);
      chk("t6_q", int'(q), 8'h33); chk("t6_ldone", d, 1);

      for (int i = 0; i < 40; i++) begin
         logic [1:0] c;
         logic [7:0] o;
         logic [3:0] p;
         int         ab;
         c  = 2'($urandom_range(0, 3));
         o  = 8'($urandom);
         p  = 4'($urandom_range(0, 2));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         if (c == CMD_FREE) ab = int'($urandom_range(0, 60));
         run_cmd(c, o, p, ab, -1, 2000, e, d);
         $display("rand %0d: cmd=%0d op=%h presc=%0d abort_at=%0d en=%0d done=%0d q=%h",
                  i, c, o, p, ab, e, d, q);
         chk("rand_done", d, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
